// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Control-side supervisor for the HDMI clock PLL, clocked by the 24 MHz
//   refclk. It pulses the PLL reset, waits for the PLL to report lock
//   (retrying on timeout), qualifies the lock for a stable interval, and only
//   then releases the reset of the PLL-clocked video/TMDS domains. Losing lock
//   while running re-sequences the PLL and counts the loss.
//
// Ports:
//   refclk     in   24 MHz crystal clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   extlock    in   PLL lock indication, asynchronous to refclk
//   pll_reset  out  active-high reset to the PLL
//   sys_rst_n  out  active-low reset for the PLL-clocked domains
//   locked     out  high while in RUN
//   fail       out  high in FAIL (retry limit reached)
//   loss_cnt   out  [7:0] count of lock losses from RUN, saturating at 255
//
// Optional feature:
//   PLL_RETRY_LIMIT_EN - when defined, MAX_RETRY consecutive lock timeouts
//   park the block in FAIL until rst_n. When undefined, retries continue
//   forever, fail is tied low and no retry counter is built.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 24,
    parameter int LOCK_TIMEOUT_CYC = 24000,
    parameter int STABLE_CYC       = 240,
    parameter int MAX_RETRY        = 4,
    parameter int TMR_W            = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);

    // Reject parameter sets whose terminal counts do not fit in the timer.
    if ((RST_PULSE_CYC < 1) || (LOCK_TIMEOUT_CYC < 1) || (STABLE_CYC < 1) ||
        (MAX_RETRY < 1) || (TMR_W < 1) || (TMR_W > 30) ||
        (RST_PULSE_CYC > (1 << TMR_W)) ||
        (LOCK_TIMEOUT_CYC > (1 << TMR_W)) ||
        (STABLE_CYC > (1 << TMR_W))) begin : g_param_check
        $error("pll_lock_supervisor: illegal parameter combination");
    end

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             sync1, lock_s;
    logic             pll_reset_n, sys_rst_n_n, locked_n;
    logic [7:0]       loss_cnt_n;

`ifdef PLL_RETRY_LIMIT_EN
    localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic [RETRY_W-1:0] retry, retry_n;
    logic               fail_q, fail_n;

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= extlock;
            lock_s <= sync1;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            loss_cnt  <= 8'd0;
`ifdef PLL_RETRY_LIMIT_EN
            retry     <= '0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            pll_reset <= pll_reset_n;
            sys_rst_n <= sys_rst_n_n;
            locked    <= locked_n;
            loss_cnt  <= loss_cnt_n;
`ifdef PLL_RETRY_LIMIT_EN
            retry     <= retry_n;
            fail_q    <= fail_n;
`endif
        end
    end

    // Next-state logic. Output next values are those seen after the edge that
    // enters the target state, so every transition sets them explicitly.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        pll_reset_n = pll_reset;
        sys_rst_n_n = sys_rst_n;
        locked_n    = locked;
        loss_cnt_n  = loss_cnt;
`ifdef PLL_RETRY_LIMIT_EN
        retry_n     = retry;
        fail_n      = fail_q;
`endif

        case (state)
            PLL_RST: begin
                pll_reset_n = 1'b1;
                sys_rst_n_n = 1'b0;
                locked_n    = 1'b0;
                if (timer == RST_LAST) begin
                    state_n     = WAIT_LOCK;
                    timer_n     = '0;
                    pll_reset_n = 1'b0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            WAIT_LOCK: begin
                pll_reset_n = 1'b0;
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_n = STABLE;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    timer_n     = '0;
                    pll_reset_n = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                    if (retry == RETRY_LAST) begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                    end else begin
                        state_n = PLL_RST;
                        retry_n = retry + RETRY_W'(1);
                    end
`else
                    state_n = PLL_RST;
`endif
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            STABLE: begin
                // A dropout here is a glitch: re-wait without a new PLL reset.
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end else if (timer == STABLE_LAST) begin
                    state_n     = RUN;
                    timer_n     = '0;
                    sys_rst_n_n = 1'b1;
                    locked_n    = 1'b1;
`ifdef PLL_RETRY_LIMIT_EN
                    retry_n     = '0;
`endif
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            RUN: begin
                if (!lock_s) begin
                    state_n     = PLL_RST;
                    timer_n     = '0;
                    pll_reset_n = 1'b1;
                    sys_rst_n_n = 1'b0;
                    locked_n    = 1'b0;
                    if (loss_cnt != 8'hFF) begin
                        loss_cnt_n = loss_cnt + 8'd1;
                    end
                end
            end

            FAIL: begin
                pll_reset_n = 1'b1;
                sys_rst_n_n = 1'b0;
                locked_n    = 1'b0;
            end

            default: begin
                state_n     = PLL_RST;
                timer_n     = '0;
                pll_reset_n = 1'b1;
                sys_rst_n_n = 1'b0;
                locked_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed self-checking bench for pll_lock_supervisor with shortened timing
// (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRY=3).
// Edge numbers in the tasks count rising edges after the stimulus change;
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       extlock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fail;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (20),
        .STABLE_CYC       (8),
        .MAX_RETRY        (3),
        .TMR_W            (16)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .extlock   (extlock),
        .pll_reset (pll_reset),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .fail      (fail),
        .loss_cnt  (loss_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, release with extlock high, and wait (bounded) for RUN.
    task automatic bring_up(output bit ok);
        rst_n   = 1'b0;
        extlock = 1'b0;
        tick();
        rst_n   = 1'b1;
        extlock = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sys_rst_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        extlock = 1'b0;
        ticks(2);
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_reset: got %b want 1", pll_reset); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
        checks++; if (fail !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail: got %b want 0", fail); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_loss_cnt: got %0d want 0", loss_cnt); end
    endtask

    task automatic test_clean_lock();
        logic exp;
        rst_n   = 1'b0;
        extlock = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = (e < 4);
            checks++; if (pll_reset !== exp) begin errors++; $display("[TB] FAIL clean_pll_reset e%0d: got %b want %b", e, pll_reset, exp); end
        end
        extlock = 1'b1;
        ticks(10);
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL clean_early_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL clean_early_locked: got %b want 0", locked); end
        tick();
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL clean_sys_rst_n: got %b want 1", sys_rst_n); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clean_locked: got %b want 1", locked); end
        checks++; if (fail !== 1'b0) begin errors++; $display("[TB] FAIL clean_fail: got %b want 0", fail); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("[TB] FAIL clean_loss_cnt: got %0d want 0", loss_cnt); end
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("[TB] FAIL clean_pll_reset_run: got %b want 0", pll_reset); end
    endtask

    task automatic test_glitch();
        bit pulse;
        rst_n   = 1'b0;
        extlock = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(4);
        pulse = 1'b0;
        // STABLE is entered on edge 3; a low sample on edge 7 reaches the
        // FSM while its timer is 5.
        for (int e = 1; e <= 18; e++) begin
            extlock = (e == 7) ? 1'b0 : 1'b1;
            tick();
            if (pll_reset !== 1'b0) pulse = 1'b1;
            if (e == 17) begin
                checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL glitch_early_sys_rst_n: got %b want 0", sys_rst_n); end
            end
            if (e == 18) begin
                checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL glitch_sys_rst_n: got %b want 1", sys_rst_n); end
            end
        end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL glitch_no_pll_reset: got %b want 0", pulse); end
    endtask

    task automatic test_timeout();
        logic exp_p;
        logic exp_f;
        rst_n   = 1'b0;
        extlock = 1'b0;
        tick();
        rst_n = 1'b1;
        // Timeouts land on edges 24, 48 and 72 after release.
        for (int e = 1; e <= 80; e++) begin
            tick();
`ifdef PLL_RETRY_LIMIT_EN
            exp_p = (e >= 72) ? 1'b1 : ((e % 24) < 4);
            exp_f = (e >= 72);
`else
            exp_p = ((e % 24) < 4);
            exp_f = 1'b0;
`endif
            checks++; if (pll_reset !== exp_p) begin errors++; $display("[TB] FAIL timeout_pll_reset e%0d: got %b want %b", e, pll_reset, exp_p); end
            checks++; if (fail !== exp_f) begin errors++; $display("[TB] FAIL timeout_fail e%0d: got %b want %b", e, fail, exp_f); end
        end
    endtask

    task automatic test_simultaneous();
        rst_n   = 1'b0;
        extlock = 1'b0;
        tick();
        rst_n = 1'b1;
        // lock_s first reads high at edge 24, the 20th WAIT_LOCK cycle.
        for (int e = 1; e <= 32; e++) begin
            if (e == 22) extlock = 1'b1;
            tick();
            if (e == 24) begin
                checks++; if (pll_reset !== 1'b0) begin errors++; $display("[TB] FAIL simul_pll_reset: got %b want 0", pll_reset); end
            end
            if (e == 31) begin
                checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL simul_early_sys_rst_n: got %b want 0", sys_rst_n); end
            end
            if (e == 32) begin
                checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL simul_sys_rst_n: got %b want 1", sys_rst_n); end
            end
        end
    endtask

    task automatic test_lock_loss();
        bit ok;
        bring_up(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL loss_bring_up: got %b want 1", ok); end
        extlock = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            if (e == 7) extlock = 1'b1;
            tick();
            if (e == 2) begin
                checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL loss_early_sys_rst_n: got %b want 1", sys_rst_n); end
            end
            if (e == 3) begin
                checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL loss_sys_rst_n: got %b want 0", sys_rst_n); end
                checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL loss_locked: got %b want 0", locked); end
                checks++; if (loss_cnt !== 8'd1) begin errors++; $display("[TB] FAIL loss_cnt_1: got %0d want 1", loss_cnt); end
                checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL loss_pll_reset_start: got %b want 1", pll_reset); end
            end
            if (e == 6) begin
                checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL loss_pll_reset_last: got %b want 1", pll_reset); end
            end
            if (e == 7) begin
                checks++; if (pll_reset !== 1'b0) begin errors++; $display("[TB] FAIL loss_pll_reset_end: got %b want 0", pll_reset); end
            end
            if (e == 16) begin
                checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL loss_relock_early: got %b want 0", sys_rst_n); end
            end
            if (e == 17) begin
                checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL loss_relock_sys_rst_n: got %b want 1", sys_rst_n); end
                checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL loss_relock_locked: got %b want 1", locked); end
            end
        end
        for (int k = 2; k <= 300; k++) begin
            extlock = 1'b0;
            ticks(6);
            extlock = 1'b1;
            ticks(11);
            if (k == 254) begin
                checks++; if (loss_cnt !== 8'd254) begin errors++; $display("[TB] FAIL loss_cnt_254: got %0d want 254", loss_cnt); end
            end
            if (k == 255) begin
                checks++; if (loss_cnt !== 8'd255) begin errors++; $display("[TB] FAIL loss_cnt_255: got %0d want 255", loss_cnt); end
            end
        end
        checks++; if (loss_cnt !== 8'd255) begin errors++; $display("[TB] FAIL loss_cnt_sat: got %0d want 255", loss_cnt); end
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL loss_final_sys_rst_n: got %b want 1", sys_rst_n); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bring_up(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL mid_bring_up: got %b want 1", ok); end
        for (int k = 0; k < 2; k++) begin
            extlock = 1'b0;
            ticks(6);
            extlock = 1'b1;
            ticks(11);
        end
        checks++; if (loss_cnt !== 8'd2) begin errors++; $display("[TB] FAIL mid_loss_cnt_2: got %0d want 2", loss_cnt); end
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_run: got %b want 1", sys_rst_n); end
        rst_n = 1'b0;
        tick();
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL mid_pll_reset: got %b want 1", pll_reset); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL mid_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL mid_locked: got %b want 0", locked); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_loss_cnt: got %0d want 0", loss_cnt); end
        checks++; if (fail !== 1'b0) begin errors++; $display("[TB] FAIL mid_fail: got %b want 0", fail); end
        rst_n = 1'b1;
        tick();
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("[TB] FAIL mid_pulse_after: got %b want 1", pll_reset); end
    endtask

    initial begin
        rst_n   = 1'b0;
        extlock = 1'b0;
        $display("[TB] starting pll_lock_supervisor bench");
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout();
        test_simultaneous();
        test_lock_loss();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
